// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection front-end and controller: debounce
// states, light codes and controller state codes.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_LO = 2'd0,
    P_HI = 2'd1,
    S_HI = 2'd2,
    P_LO = 2'd3
  } db_state_e;

  typedef enum logic [1:0] {
    NAN   = 2'd0,
    GREEN = 2'd1,
    YEL   = 2'd2,
    RED   = 2'd3
  } light_e;

  typedef enum logic [2:0] {
    CS_NS_GO    = 3'd0,
    CS_NS_SLOW  = 3'd1,
    CS_ALL_RED1 = 3'd2,
    CS_EW_GO    = 3'd3,
    CS_EW_SLOW  = 3'd4,
    CS_ALL_RED2 = 3'd5,
    CS_WALK     = 3'd6
  } ctrl_state_e;

  // Accepted level is high while settled high or while a fall is still pending.
  function automatic logic db_level(input db_state_e s);
    return (s == S_HI) || (s == P_LO);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Four-state debounce filter for one synchronised input: accepts a level change
// only after DEBOUNCE_CYCLES consecutive stable samples; registered level and rise.
module debounce_filter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_s,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_rise;
  logic             w_level_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_level_nxt & ~r_level;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LO: begin
        if (in_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = S_HI;
          end else begin
            w_state_nxt = P_HI;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      P_HI: begin
        if (!in_s) begin
          w_state_nxt = S_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HI: begin
        if (!in_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt = S_LO;
          end else begin
            w_state_nxt = P_LO;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      P_LO: begin
        if (in_s) begin
          w_state_nxt = S_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LO;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = db_level(w_state_nxt);
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/traffic_input_conditioner.sv
// Front end for the intersection controller: input synchronisers, debounce,
// sticky walk request and the state-advance tick enable.
// Optional walk lockout after acknowledge: define TRAFFIC_WALK_LOCKOUT_EN.
module traffic_input_conditioner
  import traffic_pkg::*;
#(
  parameter int DIV_COUNT       = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LOCKOUT_TICKS   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  input  logic walk_raw,
  input  logic walk_ack,
  output logic tick,
  output logic sensor_db,
  output logic walk_press,
  output logic walk_req
);

  localparam int TICK_W = $clog2(DIV_COUNT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_COUNT - 1);
  localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(DIV_COUNT - 2);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  if (DIV_COUNT < 2) begin : g_bad_div
    $error("DIV_COUNT must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LOCKOUT_TICKS < 1) begin : g_bad_lock
    $error("LOCKOUT_TICKS must be at least 1");
  end

  logic              r_sensor_s1;
  logic              r_sensor_s2;
  logic              r_walk_s1;
  logic              r_walk_s2;
  logic              w_sensor_level;
  logic              w_sensor_rise_unused;
  logic              w_walk_level_unused;
  logic              w_walk_rise;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_tick;
  logic              r_walk_press;
  logic              r_walk_req;
  logic              w_walk_req_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sensor_s1 <= 1'b0;
      r_sensor_s2 <= 1'b0;
      r_walk_s1   <= 1'b0;
      r_walk_s2   <= 1'b0;
    end else begin
      r_sensor_s1 <= sensor_raw;
      r_sensor_s2 <= r_sensor_s1;
      r_walk_s1   <= walk_raw;
      r_walk_s2   <= r_walk_s1;
    end
  end

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sensor_db (
    .clk  (clk),
    .reset(reset),
    .in_s (r_sensor_s2),
    .level(w_sensor_level),
    .rise (w_sensor_rise_unused)
  );

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_walk_db (
    .clk  (clk),
    .reset(reset),
    .in_s (r_walk_s2),
    .level(w_walk_level_unused),
    .rise (w_walk_rise)
  );

  // Tick is registered one count early so it is high while the counter sits at its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TICK_ONE;
      r_tick     <= (r_tick_cnt == TICK_PRE);
    end
  end

`ifdef TRAFFIC_WALK_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCKOUT_TICKS + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_TICKS);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

  logic [LOCK_W-1:0] r_lock_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock_cnt <= '0;
    end else if (walk_ack) begin
      r_lock_cnt <= LOCK_LOAD;
    end else if (r_tick && (r_lock_cnt != '0)) begin
      r_lock_cnt <= r_lock_cnt - LOCK_ONE;
    end
  end

  // Ack dominates: a press landing with the ack is swallowed by the new lockout.
  always_comb begin
    w_walk_req_nxt = r_walk_req;
    if (walk_ack) begin
      w_walk_req_nxt = 1'b0;
    end else if (r_walk_press && (r_lock_cnt == '0)) begin
      w_walk_req_nxt = 1'b1;
    end
  end
`else
  // Press dominates so a press during the walk phase queues the next one.
  always_comb begin
    w_walk_req_nxt = r_walk_req;
    if (r_walk_press) begin
      w_walk_req_nxt = 1'b1;
    end else if (walk_ack) begin
      w_walk_req_nxt = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_walk_press <= 1'b0;
      r_walk_req   <= 1'b0;
    end else begin
      r_walk_press <= w_walk_rise;
      r_walk_req   <= w_walk_req_nxt;
    end
  end

  assign tick       = r_tick;
  assign sensor_db  = w_sensor_level;
  assign walk_press = r_walk_press;
  assign walk_req   = r_walk_req;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Scoreboard bench for traffic_input_conditioner (DIV_COUNT=10, DEBOUNCE_CYCLES=4,
// LOCKOUT_TICKS=2); expectations follow TRAFFIC_WALK_LOCKOUT_EN when defined.
module tb_traffic_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic sensor_raw;
  logic walk_raw;
  logic walk_ack;
  logic tick;
  logic sensor_db;
  logic walk_press;
  logic walk_req;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Expected events encoded as cycle*2 + value.
  int exp_tick[$];
  int exp_press[$];
  int exp_sdb[$];
  int exp_req[$];

  logic prev_sdb = 1'b0;
  logic prev_req = 1'b0;

  traffic_input_conditioner #(
    .DIV_COUNT      (10),
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_TICKS  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sensor_raw(sensor_raw),
    .walk_raw  (walk_raw),
    .walk_ack  (walk_ack),
    .tick      (tick),
    .sensor_db (sensor_db),
    .walk_press(walk_press),
    .walk_req  (walk_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_evt(input string name, input int kind, input int act_cyc, input logic act_val);
    int  want;
    bit  have;
    want = 0;
    have = 1'b0;
    case (kind)
      0: if (exp_tick.size() > 0)  begin want = exp_tick.pop_front();  have = 1'b1; end
      1: if (exp_press.size() > 0) begin want = exp_press.pop_front(); have = 1'b1; end
      2: if (exp_sdb.size() > 0)   begin want = exp_sdb.pop_front();   have = 1'b1; end
      default: if (exp_req.size() > 0) begin want = exp_req.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected event: got cycle %0d value %0d, required none", name, act_cyc, act_val);
    end else if (want != act_cyc * 2 + int'(act_val)) begin
      errors++;
      $display("FAIL %s got cycle %0d value %0d, required cycle %0d value %0d",
               name, act_cyc, act_val, want / 2, want % 2);
    end
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %b, required %b", name, act, req);
    end
  endtask

  task automatic chk_empty(input string name, input int left);
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL %s missing events: got %0d outstanding, required 0", name, left);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every output event against the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      prev_sdb = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (tick)                    check_evt("tick", 0, cyc, 1'b1);
      if (walk_press)              check_evt("walk_press", 1, cyc, 1'b1);
      if (sensor_db !== prev_sdb)  check_evt("sensor_db", 2, cyc, sensor_db);
      if (walk_req !== prev_req)   check_evt("walk_req", 3, cyc, walk_req);
      prev_sdb = sensor_db;
      prev_req = walk_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    sensor_raw = 1'b0;
    walk_raw   = 1'b0;
    walk_ack   = 1'b0;
    #12;
    chk("reset_tick", tick, 1'b0);
    chk("reset_sensor_db", sensor_db, 1'b0);
    chk("reset_walk_press", walk_press, 1'b0);
    chk("reset_walk_req", walk_req, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    for (int m = 0; m < 18; m++) exp_tick.push_back((9 + 10 * m) * 2 + 1);

    // Bouncing button, final rise at 48: press at 55, request at 56.
    to_cyc(40); walk_raw = 1'b1;
    to_cyc(42); walk_raw = 1'b0;
    to_cyc(44); walk_raw = 1'b1;
    to_cyc(46); walk_raw = 1'b0;
    to_cyc(48); walk_raw = 1'b1;
    exp_press.push_back(55 * 2 + 1);
    exp_req.push_back(56 * 2 + 1);

    // Acknowledge clears; a second ack with no request does nothing.
    to_cyc(60); walk_ack = 1'b1; exp_req.push_back(61 * 2 + 0);
    to_cyc(61); walk_ack = 1'b0;
    to_cyc(65); walk_ack = 1'b1;
    to_cyc(66); walk_ack = 1'b0;
    to_cyc(70); walk_raw = 1'b0;

    // Sensor glitch of 3 cycles is rejected; 10-cycle pulse passes.
    to_cyc(80);  sensor_raw = 1'b1;
    to_cyc(83);  sensor_raw = 1'b0;
    to_cyc(90);  sensor_raw = 1'b1;
    exp_sdb.push_back(96 * 2 + 1);
    exp_sdb.push_back(106 * 2 + 0);
    to_cyc(100); sensor_raw = 1'b0;

    // New request.
    to_cyc(110); walk_raw = 1'b1;
    exp_press.push_back(117 * 2 + 1);
    exp_req.push_back(118 * 2 + 1);
    to_cyc(120); walk_raw = 1'b0;

    // Press at 137 collides with an ack.
    to_cyc(130); walk_raw = 1'b1;
    exp_press.push_back(137 * 2 + 1);
`ifdef TRAFFIC_WALK_LOCKOUT_EN
    exp_req.push_back(138 * 2 + 0);
`endif
    to_cyc(134); walk_raw = 1'b0;
    to_cyc(137); walk_ack = 1'b1;
    to_cyc(138); walk_ack = 1'b0; walk_raw = 1'b1;
    exp_press.push_back(145 * 2 + 1);

    // Press after lockout has expired.
    to_cyc(150); walk_raw = 1'b0;
    to_cyc(156); walk_raw = 1'b1;
    exp_press.push_back(163 * 2 + 1);
`ifdef TRAFFIC_WALK_LOCKOUT_EN
    exp_req.push_back(164 * 2 + 1);
`endif
    to_cyc(166); walk_raw = 1'b0;
    to_cyc(170); sensor_raw = 1'b1;
    exp_sdb.push_back(176 * 2 + 1);
    to_cyc(178); walk_raw = 1'b1;

    // Asynchronous reset mid-debounce with request and sensor high.
    to_cyc(182);
    #2;
    reset      = 1'b0;
    sensor_raw = 1'b0;
    walk_raw   = 1'b0;
    #1;
    chk("async_tick", tick, 1'b0);
    chk("async_sensor_db", sensor_db, 1'b0);
    chk("async_walk_press", walk_press, 1'b0);
    chk("async_walk_req", walk_req, 1'b0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_tick.push_back(9 * 2 + 1);
    exp_tick.push_back(19 * 2 + 1);
    exp_tick.push_back(29 * 2 + 1);
    to_cyc(35);

    chk_empty("tick_queue", exp_tick.size());
    chk_empty("press_queue", exp_press.size());
    chk_empty("sensor_queue", exp_sdb.size());
    chk_empty("req_queue", exp_req.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
